mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..3.
REQ-002 cclk  in  1  single clock; all state changes on rising edge.
REQ-003 rstb  in  1  asynchronous, active-low reset.
REQ-004 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-005 cpu_we  in  1  CPU write (1) or read (0).
REQ-006 cpu_addr, cpu_wdata  in  32 each  CPU address and write data.
REQ-007 cpu_rdata  out  32  CPU read data; valid only while cpu_ack=1.
REQ-008 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-009 ldr_req, ldr_we, ldr_addr[31:0], ldr_wdata[31:0] in; ldr_rdata[31:0], ldr_ack out: boot-loader port, same semantics as the CPU port.
REQ-010 mem_re, mem_we  out  1 each  memory read and write strobes.
REQ-011 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-012 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_re cycle.

Function
REQ-013 FSM states: IDLE, ACCESS, WAIT, RESP; owner register selects CPU or LDR.
REQ-014 IDLE: if any req is high, latch the winner's we, addr and wdata, set owner, and go to ACCESS next cycle; otherwise stay in IDLE.
REQ-015 ACCESS: drive mem_addr/mem_wdata from the latched values for one cycle; mem_re=~we, mem_we=we; write goes to RESP; read goes to WAIT.
REQ-016 WAIT: hold for MEM_LAT cycles using a down-counter; capture mem_rdata into the read register at the end of the last WAIT cycle; then go to RESP.
REQ-017 RESP: assert the owner's ack for exactly one cycle and drive the owner's rdata from the read register; then go to IDLE.
REQ-018 Latency from the req-sampled cycle T to the ack cycle: read = MEM_LAT+2, write = 2; no new grant before IDLE, so there is at least one idle cycle between transactions.
REQ-019 The non-owner's ack stays 0; both rdata outputs hold their last value outside RESP.
REQ-020 mem_re and mem_we are never high together, and are high only in ACCESS.
REQ-021 If req drops mid-transaction, the transaction still completes and ack still pulses; the requester ignores it.
REQ-022 If req stays high in the ack cycle, it is a new request and is sampled in the following IDLE cycle.
REQ-023 Latched addr, wdata and we remain stable from ACCESS through RESP regardless of input changes.

Reset
REQ-024 rstb low at any time, including mid-transaction, forces state IDLE, owner CPU, counter 0 and the read register 0.
REQ-025 rstb low forces all outputs (acks, strobes, mem_addr, mem_wdata, rdata) to 0 immediately.
REQ-026 Any in-flight transaction is abandoned with no ack.
REQ-027 The first grant is possible in the first cycle after rstb rises.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the requester that was not granted last; the last-granted flag resets to LDR, so CPU wins the first tie.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins ties; the last-granted flag is not implemented.

Structure
REQ-030 The FSM state encodings and owner encodings (CPU=0, LDR=1) live in the shared package mips_pkg, next to the control-unit state encodings.
REQ-031 The WAIT counter is implemented as sub-module mem_lat_timer: load MEM_LAT, decrement, assert done at 1.
REQ-032 The FSM, arbitration and latching stay in mem_arbiter.

Verification
REQ-033 rstb pulsed low while in WAIT -> next sampled state IDLE, no ack, mem_re=0.
REQ-034 MEM_LAT=1, CPU read addr 0x40 returning 0xDEADBEEF, req at cycle 0 -> mem_re=1 at cycle 1, cpu_ack=1 and cpu_rdata=0xDEADBEEF at cycle 3.
REQ-035 LDR write addr 0x100 data 0x12345678 -> mem_we=1 with those values at cycle 1, ldr_ack at cycle 2, cpu_ack stays 0.
REQ-036 cpu_req and ldr_req both high and held -> fixed priority: CPU served repeatedly, LDR starves; ARB_ROUND_ROBIN_EN: grants alternate CPU, LDR, CPU.
REQ-037 MEM_LAT=3 read -> ack at cycle 5; cpu_addr changed during WAIT -> mem_addr unchanged.
REQ-038 cpu_req dropped in ACCESS -> cpu_ack still pulses in RESP; FSM returns to IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: control-unit states, memory arbiter
// FSM states, bus owner encoding and the latched memory request record.
package mips_pkg;

   typedef enum logic [2:0] {
      CU_FETCH, CU_DECODE, CU_EXEC, CU_MEM, CU_WB
   } cu_state_t;

   typedef enum logic [1:0] {
      ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // wide enough for MEM_LAT up to 3
   localparam int LAT_W = 2;

endpackage

// File: rtl/mem_lat_timer.sv
// Read-latency down-counter: loads MEM_LAT, counts down while enabled and
// flags done on the final count so the caller can capture read data.
module mem_lat_timer
   import mips_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic cclk,
   input  logic rstb,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(MEM_LAT);

   logic [LAT_W-1:0] cnt;

   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb)                    cnt <= '0;
      else if (load)                cnt <= LOAD_VAL;
      else if (en && cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / boot loader) single-outstanding memory arbiter.
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties; default is CPU priority.
module mem_arbiter
   import mips_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        cclk,
   input  logic        rstb,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        ldr_req,
   input  logic        ldr_we,
   input  logic [31:0] ldr_addr,
   input  logic [31:0] ldr_wdata,
   output logic [31:0] ldr_rdata,
   output logic        ldr_ack,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   arb_state_t  state, state_nxt;
   owner_t      owner;
   mem_req_t    req_q;
   logic [31:0] rd_q, cpu_rd_q, ldr_rd_q;
   logic        grant, grant_ldr, lat_done;

   assign grant = cpu_req || ldr_req;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_q;

   // on a tie, the port that did not win last time gets the bus
   assign grant_ldr = ldr_req && (!cpu_req || last_q == OWN_CPU);

   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb)                          last_q <= OWN_LDR;
      else if (state == ARB_IDLE && grant) last_q <= grant_ldr ? OWN_LDR : OWN_CPU;
   end
`else
   assign grant_ldr = ldr_req && !cpu_req;
`endif

   mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
      .cclk (cclk),
      .rstb (rstb),
      .load (state == ARB_ACCESS && !req_q.we),
      .en   (state == ARB_WAIT),
      .done (lat_done)
   );

   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) state <= ARB_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      cpu_ack   = 1'b0;
      ldr_ack   = 1'b0;
      case (state)
         ARB_IDLE:   if (grant) state_nxt = ARB_ACCESS;
         ARB_ACCESS: begin
            mem_re    = !req_q.we;
            mem_we    = req_q.we;
            state_nxt = req_q.we ? ARB_RESP : ARB_WAIT;
         end
         ARB_WAIT:   if (lat_done) state_nxt = ARB_RESP;
         ARB_RESP: begin
            cpu_ack   = (owner == OWN_CPU);
            ldr_ack   = (owner == OWN_LDR);
            state_nxt = ARB_IDLE;
         end
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   // request is frozen at grant; inputs are ignored until the next IDLE
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         owner    <= OWN_CPU;
         req_q    <= '0;
         rd_q     <= '0;
         cpu_rd_q <= '0;
         ldr_rd_q <= '0;
      end else begin
         if (state == ARB_IDLE && grant) begin
            owner <= grant_ldr ? OWN_LDR : OWN_CPU;
            req_q <= grant_ldr ? {ldr_we, ldr_addr, ldr_wdata}
                               : {cpu_we, cpu_addr, cpu_wdata};
         end
         if (state == ARB_WAIT && lat_done) rd_q <= mem_rdata;
         if (state == ARB_RESP) begin
            if (owner == OWN_CPU) cpu_rd_q <= rd_q;
            else                  ldr_rd_q <= rd_q;
         end
      end
   end

   assign cpu_rdata = cpu_ack ? rd_q : cpu_rd_q;
   assign ldr_rdata = ldr_ack ? rd_q : ldr_rd_q;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;

endmodule
